// File: rtl/dcache_writeback.sv
// Victim write-back engine: buffers one dirty line, bursts it to memory word by word,
// pulses the dirty-bit clear, and serves load-path probes while the line is held.
module dcache_writeback #(
    parameter int ADDR_W  = 32,
    parameter int WORDS   = 4,
    parameter int INDEX_W = 5,
    parameter int OFF_W   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_req,
    input  logic [ADDR_W-1:0]     wb_addr,
    input  logic [32*WORDS-1:0]   wb_line,
    input  logic                  wb_way,
    input  logic [INDEX_W-1:0]    wb_index,
    output logic                  wb_ready,
    output logic                  wb_done,
    output logic                  mem_wvalid,
    output logic [ADDR_W-1:0]     mem_waddr,
    output logic [31:0]           mem_wdata,
    output logic                  mem_wlast,
    input  logic                  mem_wready,
    output logic                  dty_clr,
    output logic                  dty_way,
    output logic [INDEX_W-1:0]    dty_index,
    input  logic [ADDR_W-1:0]     probe_addr,
    output logic                  probe_hit,
    output logic [31:0]           probe_data
);

    localparam int CNT_W = $clog2(WORDS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t                state, state_next;
    logic [CNT_W-1:0]      cnt;
    logic [ADDR_W-1:0]     base;
    logic [31:0]           words [WORDS];
    logic                  way;
    logic [INDEX_W-1:0]    index;
    logic                  accept;
    logic                  busy;

    assign accept = (state == IDLE) && wb_req;
    assign busy   = (state != IDLE);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= '0;
        end else if (state == SEND && mem_wready) begin
            cnt <= cnt + 1'b1;
        end
    end

    // NOTE: the line buffer and its tags are not reset; every use is gated by state, and they reload on accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            base  <= {wb_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            way   <= wb_way;
            index <= wb_index;
            for (int k = 0; k < WORDS; k++) begin
                words[k] <= wb_line[32*k +: 32];
            end
        end
    end

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        wb_ready   = 1'b0;
        wb_done    = 1'b0;
        dty_clr    = 1'b0;
        dty_way    = 1'b0;
        dty_index  = '0;
        mem_wvalid = 1'b0;
        mem_waddr  = '0;
        mem_wdata  = '0;
        mem_wlast  = 1'b0;
        case (state)
            IDLE: begin
                wb_ready = 1'b1;
                if (wb_req) state_next = SEND;
            end
            SEND: begin
                mem_wvalid = 1'b1;
                mem_waddr  = base + ADDR_W'({cnt, 2'b00});
                mem_wdata  = words[cnt];
                mem_wlast  = (cnt == LAST_CNT);
                if (mem_wready && cnt == LAST_CNT) state_next = DONE;
            end
            DONE: begin
                wb_done    = 1'b1;
                dty_clr    = 1'b1;
                dty_way    = way;
                dty_index  = index;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The buffer stays readable through DONE so a load racing the eviction still forwards.
    always_comb begin
        probe_hit  = 1'b0;
        probe_data = '0;
        if (busy) begin
            probe_hit  = (probe_addr[ADDR_W-1:OFF_W] == base[ADDR_W-1:OFF_W]);
            probe_data = words[probe_addr[OFF_W-1:2]];
        end
    end

    // Sub-word offset bits carry no information for line-granular traffic.
    logic unused_offset_bits;
    assign unused_offset_bits = ^{wb_addr[OFF_W-1:0], probe_addr[1:0]};

endmodule

// File: tb/tb_dcache_writeback.sv
// Directed bench for dcache_writeback: per-cycle vector table for a basic burst,
// then hand-written sequences for stalls, busy requests, reset mid-burst and back-to-back.
module tb_dcache_writeback;

    localparam int ADDR_W  = 32;
    localparam int WORDS   = 4;
    localparam int INDEX_W = 5;
    localparam int OFF_W   = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 wb_req;
    logic [ADDR_W-1:0]    wb_addr;
    logic [32*WORDS-1:0]  wb_line;
    logic                 wb_way;
    logic [INDEX_W-1:0]   wb_index;
    logic                 wb_ready;
    logic                 wb_done;
    logic                 mem_wvalid;
    logic [ADDR_W-1:0]    mem_waddr;
    logic [31:0]          mem_wdata;
    logic                 mem_wlast;
    logic                 mem_wready;
    logic                 dty_clr;
    logic                 dty_way;
    logic [INDEX_W-1:0]   dty_index;
    logic [ADDR_W-1:0]    probe_addr;
    logic                 probe_hit;
    logic [31:0]          probe_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dcache_writeback #(
        .ADDR_W(ADDR_W), .WORDS(WORDS), .INDEX_W(INDEX_W), .OFF_W(OFF_W)
    ) dut (
        .clk(clk), .rst(rst),
        .wb_req(wb_req), .wb_addr(wb_addr), .wb_line(wb_line),
        .wb_way(wb_way), .wb_index(wb_index),
        .wb_ready(wb_ready), .wb_done(wb_done),
        .mem_wvalid(mem_wvalid), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_wlast(mem_wlast), .mem_wready(mem_wready),
        .dty_clr(dty_clr), .dty_way(dty_way), .dty_index(dty_index),
        .probe_addr(probe_addr), .probe_hit(probe_hit), .probe_data(probe_data)
    );

    typedef struct {
        logic        req;
        logic        rdy;
        logic [31:0] paddr;
        logic        e_ready;
        logic        e_valid;
        logic [31:0] e_addr;
        logic [31:0] e_data;
        logic        e_last;
        logic        e_done;
        logic        e_clr;
        logic        e_way;
        logic [4:0]  e_idx;
        logic        e_hit;
        logic [31:0] e_pdata;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven from here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " wb_ready"},   64'(wb_ready),   64'd1);
        check({tag, " wb_done"},    64'(wb_done),    64'd0);
        check({tag, " mem_wvalid"}, 64'(mem_wvalid), 64'd0);
        check({tag, " mem_wlast"},  64'(mem_wlast),  64'd0);
        check({tag, " mem_waddr"},  64'(mem_waddr),  64'd0);
        check({tag, " mem_wdata"},  64'(mem_wdata),  64'd0);
        check({tag, " dty_clr"},    64'(dty_clr),    64'd0);
        check({tag, " dty_way"},    64'(dty_way),    64'd0);
        check({tag, " dty_index"},  64'(dty_index),  64'd0);
        check({tag, " probe_hit"},  64'(probe_hit),  64'd0);
        check({tag, " probe_data"}, 64'(probe_data), 64'd0);
    endtask

    // Issues one request from an IDLE cycle and follows it with a small model:
    // beat index advances on each accepted beat, DONE is expected the cycle after the last.
    task automatic run_burst(input logic [31:0] addr, input logic [127:0] line,
                             input logic way, input logic [4:0] idx,
                             input logic [15:0] rdy_pat, input bit busy_req,
                             input string tag, output int done_cyc);
        logic [31:0] base;
        int beat;
        base     = {addr[31:4], 4'h0};
        beat     = 0;
        done_cyc = -1;
        check({tag, " ready before req"}, 64'(wb_ready), 64'd1);
        wb_req   = 1'b1;
        wb_addr  = addr;
        wb_line  = line;
        wb_way   = way;
        wb_index = idx;
        tick();
        for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
            mem_wready = (c <= 16) ? rdy_pat[c-1] : 1'b1;
            if (busy_req && c == 2) begin
                wb_req   = 1'b1;
                wb_addr  = 32'h0000_9990;
                wb_line  = {4{32'hDEAD_BEEF}};
                wb_way   = ~way;
                wb_index = ~idx;
            end else begin
                wb_req = 1'b0;
            end
            #2;
            if (beat == WORDS) begin
                check($sformatf("%s wb_done c%0d", tag, c),   64'(wb_done),    64'd1);
                check($sformatf("%s dty_clr c%0d", tag, c),   64'(dty_clr),    64'd1);
                check($sformatf("%s dty_way c%0d", tag, c),   64'(dty_way),    64'(way));
                check($sformatf("%s dty_index c%0d", tag, c), 64'(dty_index),  64'(idx));
                check($sformatf("%s valid in done c%0d", tag, c), 64'(mem_wvalid), 64'd0);
                done_cyc = c;
            end else begin
                check($sformatf("%s wb_done c%0d", tag, c),  64'(wb_done),    64'd0);
                check($sformatf("%s dty_clr c%0d", tag, c),  64'(dty_clr),    64'd0);
                check($sformatf("%s wvalid c%0d", tag, c),   64'(mem_wvalid), 64'd1);
                check($sformatf("%s waddr c%0d", tag, c),    64'(mem_waddr),  64'(base + 32'(4 * beat)));
                check($sformatf("%s wdata c%0d", tag, c),    64'(mem_wdata),  64'(line[32*beat +: 32]));
                check($sformatf("%s wlast c%0d", tag, c),    64'(mem_wlast),  64'(beat == WORDS - 1));
                if (mem_wready) beat++;
            end
            tick();
        end
        wb_req     = 1'b0;
        mem_wready = 1'b1;
        #2;
        if (done_cyc < 0) check({tag, " burst timeout"}, 64'd1, 64'd0);
        check({tag, " ready after done"}, 64'(wb_ready),   64'd1);
        check({tag, " idle no valid"},    64'(mem_wvalid), 64'd0);
        check({tag, " idle no done"},     64'(wb_done),    64'd0);
    endtask

    vec_t vecs [7];
    int   dcyc;

    initial begin
        rst        = 1'b1;
        wb_req     = 1'b0;
        wb_addr    = '0;
        wb_line    = '0;
        wb_way     = 1'b0;
        wb_index   = '0;
        mem_wready = 1'b0;
        probe_addr = '0;
        tick();
        tick();
        #2;
        check_idle_outputs("reset");
        rst = 1'b0;
        tick();

        // Basic burst, one row per cycle: {req, rdy, probe, ready, valid, addr, data, last, done, clr, way, idx, hit, pdata}
        vecs[0] = '{1'b1, 1'b1, 32'h1238, 1'b1, 1'b0, 32'h0,    32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 32'h1238, 1'b0, 1'b1, 32'h1230, 32'hA0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 32'hA2};
        vecs[2] = '{1'b0, 1'b1, 32'h1240, 1'b0, 1'b1, 32'h1234, 32'hA1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'hA0};
        vecs[3] = '{1'b0, 1'b1, 32'h123C, 1'b0, 1'b1, 32'h1238, 32'hA2, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 32'hA3};
        vecs[4] = '{1'b0, 1'b1, 32'h1234, 1'b0, 1'b1, 32'h123C, 32'hA3, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 32'hA1};
        vecs[5] = '{1'b0, 1'b1, 32'h1238, 1'b0, 1'b0, 32'h0,    32'h0,  1'b0, 1'b1, 1'b1, 1'b1, 5'd3, 1'b1, 32'hA2};
        vecs[6] = '{1'b0, 1'b1, 32'h1238, 1'b1, 1'b0, 32'h0,    32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0};
        wb_addr  = 32'h0000_1234;
        wb_line  = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        wb_way   = 1'b1;
        wb_index = 5'd3;
        for (int i = 0; i < 7; i++) begin
            wb_req     = vecs[i].req;
            mem_wready = vecs[i].rdy;
            probe_addr = vecs[i].paddr;
            #2;
            check($sformatf("vec%0d wb_ready", i),   64'(wb_ready),   64'(vecs[i].e_ready));
            check($sformatf("vec%0d mem_wvalid", i), 64'(mem_wvalid), 64'(vecs[i].e_valid));
            check($sformatf("vec%0d mem_waddr", i),  64'(mem_waddr),  64'(vecs[i].e_addr));
            check($sformatf("vec%0d mem_wdata", i),  64'(mem_wdata),  64'(vecs[i].e_data));
            check($sformatf("vec%0d mem_wlast", i),  64'(mem_wlast),  64'(vecs[i].e_last));
            check($sformatf("vec%0d wb_done", i),    64'(wb_done),    64'(vecs[i].e_done));
            check($sformatf("vec%0d dty_clr", i),    64'(dty_clr),    64'(vecs[i].e_clr));
            check($sformatf("vec%0d dty_way", i),    64'(dty_way),    64'(vecs[i].e_way));
            check($sformatf("vec%0d dty_index", i),  64'(dty_index),  64'(vecs[i].e_idx));
            check($sformatf("vec%0d probe_hit", i),  64'(probe_hit),  64'(vecs[i].e_hit));
            check($sformatf("vec%0d probe_data", i), 64'(probe_data), 64'(vecs[i].e_pdata));
            if (i < 6) tick();
        end
        wb_req     = 1'b0;
        probe_addr = 32'h0000_0100;

        // Backpressure: ready pattern 0,1,0,0,1,1,1 -> three stalls, DONE three cycles later.
        run_burst(32'h0000_2007, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 1'b0, 5'd17,
                  16'b1111_1111_1111_0010, 1'b0, "stall", dcyc);
        check("stall done cycle", 64'(dcyc), 64'd8);
        tick();

        // A request during SEND must be dropped.
        run_burst(32'h0000_3010, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 1'b1, 5'd9,
                  16'hFFFF, 1'b1, "busy", dcyc);
        check("busy done cycle", 64'(dcyc), 64'd5);
        tick();
        #2;
        check("busy not queued", 64'(mem_wvalid), 64'd0);
        check("busy still ready", 64'(wb_ready), 64'd1);

        // Line at the top of the address space.
        run_burst(32'hFFFF_FFF9, {32'hD3, 32'hD2, 32'hD1, 32'hD0}, 1'b1, 5'd31,
                  16'hFFFF, 1'b0, "top", dcyc);
        check("top done cycle", 64'(dcyc), 64'd5);

        // Reset after beat 1 is accepted.
        wb_req   = 1'b1;
        wb_addr  = 32'h0000_4000;
        wb_line  = {32'hE3, 32'hE2, 32'hE1, 32'hE0};
        wb_way   = 1'b1;
        wb_index = 5'd21;
        mem_wready = 1'b1;
        tick();
        wb_req = 1'b0;
        tick();
        tick();
        #2;
        check("rst pre beat2 addr", 64'(mem_waddr), 64'h4008);
        mem_wready = 1'b0;
        rst        = 1'b1;
        probe_addr = 32'h0000_4004;
        tick();
        #2;
        check_idle_outputs("midrst");
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            #2;
            check($sformatf("midrst no clr c%0d", c),  64'(dty_clr), 64'd0);
            check($sformatf("midrst no done c%0d", c), 64'(wb_done), 64'd0);
        end
        run_burst(32'h0000_5000, {32'hF3, 32'hF2, 32'hF1, 32'hF0}, 1'b0, 5'd6,
                  16'hFFFF, 1'b0, "after rst", dcyc);
        check("after rst done cycle", 64'(dcyc), 64'd5);

        // Back-to-back: the second request is issued in the very cycle wb_ready returns.
        tick();
        run_burst(32'h0000_6000, {32'h63, 32'h62, 32'h61, 32'h60}, 1'b1, 5'd1,
                  16'hFFFF, 1'b0, "b2b first", dcyc);
        check("b2b first done", 64'(dcyc), 64'd5);
        run_burst(32'h0000_7020, {32'h73, 32'h72, 32'h71, 32'h70}, 1'b0, 5'd2,
                  16'hFFFF, 1'b0, "b2b second", dcyc);
        check("b2b second done", 64'(dcyc), 64'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
